// File: rtl/blinker_multi_timer.sv
// rtl/blinker_multi_timer.sv - N-channel programmable wrap timer with blink outputs (optional BLINK_DUTY_EN)
module blinker_multi_timer #(
  parameter int          CHANNELS   = 4,
  parameter int          WIDTH      = 26,
  parameter int unsigned DEFAULT_TC = 52428800,
  localparam int         CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                cfg_we,
`ifdef BLINK_DUTY_EN
  input  logic                cfg_duty_we,
`endif
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_tc,
  input  logic [CHANNELS-1:0] en_i,
  input  logic [CHANNELS-1:0] clr_i,
  output logic [CHANNELS-1:0] wrap_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_TC);

  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic [WIDTH-1:0]    r_tc  [CHANNELS];
  logic [CHANNELS-1:0] w_hit;

  // Terminal reached ('>=' so a lowered tc wraps at once instead of running to 2^WIDTH)
  always_comb begin
    w_hit  = '0;
    wrap_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_hit[c]  = (r_cnt[c] >= r_tc[c]);
      wrap_o[c] = en_i[c] & ~clr_i[c] & w_hit[c];
    end
  end

  // Per-channel counter: clear beats hold, hold beats wrap, wrap beats increment
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_i[c])      r_cnt[c] <= '0;
        else if (!en_i[c]) r_cnt[c] <= r_cnt[c];
        else if (w_hit[c]) r_cnt[c] <= '0;
        else               r_cnt[c] <= r_cnt[c] + WIDTH'(1);
      end
    end
  end

  // Terminal-count write; an out-of-range channel matches no slot and is dropped
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int c = 0; c < CHANNELS; c++) r_tc[c] <= TC_RST;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) r_tc[c] <= cfg_tc;
      end
    end
  end

`ifdef BLINK_DUTY_EN
  localparam logic [WIDTH-1:0] DUTY_RST = TC_RST >> 1;

  logic [WIDTH-1:0] r_duty [CHANNELS];

  // Duty-threshold write, same channel-range rule as the terminal count
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int c = 0; c < CHANNELS; c++) r_duty[c] <= DUTY_RST;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_duty_we && (cfg_ch == CH_W'(c))) r_duty[c] <= cfg_tc;
      end
    end
  end

  // PWM-style blink: high while the count is below the duty threshold
  always_comb begin
    led_o = '0;
    for (int c = 0; c < CHANNELS; c++) led_o[c] = en_i[c] & (r_cnt[c] < r_duty[c]);
  end
`else
  logic [CHANNELS-1:0] r_led;

  // Square-wave blink: toggles exactly when the channel emits its wrap strobe
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_led <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_i[c])       r_led[c] <= 1'b0;
        else if (wrap_o[c]) r_led[c] <= ~r_led[c];
      end
    end
  end

  assign led_o = r_led;
`endif

endmodule

// File: tb/tb_blinker_multi_timer.sv
// tb/tb_blinker_multi_timer.sv - self-checking bench for blinker_multi_timer (CHANNELS=2, WIDTH=8, DEFAULT_TC=9)
module tb_blinker_multi_timer;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int DTC = 9;

  logic       clk = 1'b0;
  logic       rstn;
  logic       we;
  logic [0:0] ch;
  logic [7:0] tc;
  logic [1:0] en, clr;
  logic [1:0] wrap, led;
`ifdef BLINK_DUTY_EN
  logic       duty_we = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  int m_cnt [CH];
  int m_tc  [CH];
  int m_led [CH];
  int m_duty[CH];

  always #5 clk = ~clk;

  blinker_multi_timer #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_TC(DTC)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .cfg_we          (we),
`ifdef BLINK_DUTY_EN
    .cfg_duty_we     (duty_we),
`endif
    .cfg_ch          (ch),
    .cfg_tc          (tc),
    .en_i            (en),
    .clr_i           (clr),
    .wrap_o          (wrap),
    .led_o           (led)
  );

  typedef struct {
    logic [1:0] en;
    logic [1:0] ew;
    logic [1:0] el;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c]  = 0;
      m_tc[c]   = DTC;
      m_led[c]  = 0;
      m_duty[c] = DTC / 2;
    end
  endtask

  // One clock: drive, sample mid-cycle against the model, advance the model, cross the edge
  task automatic cycle(input logic iwe, input int ich, input int itc, input logic [1:0] ien,
                       input logic [1:0] iclr, output logic [1:0] s_wrap, output logic [1:0] s_led);
    logic [1:0] e_w, e_l;
    we  = iwe;
    ch  = 1'(ich);
    tc  = 8'(itc);
    en  = ien;
    clr = iclr;
    #4;
    for (int c = 0; c < CH; c++) begin
      e_w[c] = ien[c] && !iclr[c] && (m_cnt[c] >= m_tc[c]);
`ifdef BLINK_DUTY_EN
      e_l[c] = ien[c] && (m_cnt[c] < m_duty[c]);
`else
      e_l[c] = (m_led[c] != 0);
`endif
    end
    s_wrap = wrap;
    s_led  = led;
    chk("model_wrap", {30'd0, wrap}, {30'd0, e_w});
    chk("model_led", {30'd0, led}, {30'd0, e_l});
    for (int c = 0; c < CH; c++) begin
      if (iclr[c]) begin
        m_cnt[c] = 0;
        m_led[c] = 0;
      end else if (ien[c]) begin
        if (m_cnt[c] >= m_tc[c]) begin
          m_cnt[c] = 0;
          m_led[c] = 1 - m_led[c];
        end else begin
          m_cnt[c] = (m_cnt[c] + 1) % (1 << W);
        end
      end
    end
    if (iwe && ich < CH) m_tc[ich] = itc;
`ifdef BLINK_DUTY_EN
    if (duty_we && ich < CH) m_duty[ich] = itc;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_cnt0(input int target, input string name);
    logic [1:0] sw, sl;
    int n;
    n = 0;
    while (m_cnt[0] != target && n < 300) begin
      cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
      n++;
    end
    if (m_cnt[0] != target) begin
      errors++;
      checks++;
      $display("FAIL %s: count %0d never reached %0d", name, m_cnt[0], target);
    end
  endtask

  initial begin
    logic [1:0] sw, sl, prev_l;
    int nw, first;

    for (int i = 0; i < 22; i++) begin
      tbl[i].en = 2'b01;
      tbl[i].ew = (i % 10 == 9) ? 2'b01 : 2'b00;
      tbl[i].el = ((i / 10) % 2 == 1) ? 2'b01 : 2'b00;
    end

    rstn = 1'b0; we = 1'b0; ch = '0; tc = '0; en = '0; clr = '0;
    model_reset();
    #2;
    chk("reset_wrap", {30'd0, wrap}, 32'd0);
    chk("reset_led", {30'd0, led}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Default period from reset: wrap on 10th enabled cycle, ch1 idle
    for (int i = 0; i < 22; i++) begin
      cycle(1'b0, 0, 0, tbl[i].en, 2'b00, sw, sl);
      chk($sformatf("tbl_wrap[%0d]", i), {30'd0, sw}, {30'd0, tbl[i].ew});
`ifndef BLINK_DUTY_EN
      chk($sformatf("tbl_led[%0d]", i), {30'd0, sl}, {30'd0, tbl[i].el});
`endif
    end

    // Clear mid-count, then clear exactly at terminal suppresses wrap
    run_until_cnt0(5, "reach_cnt5");
    cycle(1'b0, 0, 0, 2'b01, 2'b01, sw, sl);
    chk("clr_no_wrap", {31'd0, sw[0]}, 32'd0);
    cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
`ifndef BLINK_DUTY_EN
    chk("clr_led_low", {31'd0, sl[0]}, 32'd0);
`endif
    run_until_cnt0(9, "reach_cnt9");
    cycle(1'b0, 0, 0, 2'b01, 2'b01, sw, sl);
    chk("clr_at_tc_no_wrap", {31'd0, sw[0]}, 32'd0);

    // tc=0 on ch1: wrap every cycle, led toggles each cycle
    cycle(1'b1, 1, 0, 2'b00, 2'b10, sw, sl);
    cycle(1'b0, 0, 0, 2'b10, 2'b00, sw, prev_l);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 0, 0, 2'b10, 2'b00, sw, sl);
      chk("tc0_wrap", {31'd0, sw[1]}, 32'd1);
`ifndef BLINK_DUTY_EN
      chk("tc0_led_toggle", {31'd0, sl[1] ^ prev_l[1]}, 32'd1);
`endif
      prev_l = sl;
    end

    // Lower tc below live count: wrap next cycle, then period 4
    run_until_cnt0(7, "reach_cnt7");
    cycle(1'b1, 0, 3, 2'b01, 2'b00, sw, sl);
    cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
    chk("lower_tc_wrap", {31'd0, sw[0]}, 32'd1);
    chk("lower_tc_cnt", m_cnt[0], 0);
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
      nw += sw[0];
    end
    chk("period4_wraps", nw, 2);

    // Asynchronous reset mid-count restores default tc
    cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
    en = 2'b01; clr = 2'b00; we = 1'b0;
    rstn = 1'b0;
    #2;
    chk("rst_mid_wrap", {30'd0, wrap}, 32'd0);
`ifndef BLINK_DUTY_EN
    chk("rst_mid_led", {30'd0, led}, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
      if (sw[0] && first < 0) first = i;
    end
    chk("post_rst_period", first, 9);

    // tc = all-ones: single wrap after 256 enabled cycles
    cycle(1'b1, 1, 255, 2'b00, 2'b10, sw, sl);
    nw = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 0, 0, 2'b10, 2'b00, sw, sl);
      nw += sw[1];
    end
    chk("tcmax_wraps", nw, 1);
    chk("tcmax_last_wrap", {31'd0, sw[1]}, 32'd1);
    chk("tcmax_cnt_back0", m_cnt[1], 0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 12),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, sw, sl);
    end

`ifdef BLINK_DUTY_EN
    // Duty 3 of a 10-cycle period
    cycle(1'b1, 0, 9, 2'b00, 2'b01, sw, sl);
    duty_we = 1'b1;
    cycle(1'b0, 0, 3, 2'b00, 2'b00, sw, sl);
    duty_we = 1'b0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 0, 0, 2'b01, 2'b00, sw, sl);
      nw += sl[0];
    end
    chk("duty_high_cycles", nw, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
